// File: rtl/uart_rx_core_if.sv
// Serial-side and byte-side signals of the UART receive deserializer.
// The slave modport is the receiver; the master modport is whoever drives the line and consumes bytes.
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
);
    logic                 baud_clk;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output baud_clk,
        output rx,
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  baud_clk,
        input  rx,
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART receive deserializer: recovers 8N1 / 8E1 / 8O1 style frames from an oversampled line,
// using the rising edges of baud_clk as a sampling enable in the clk domain.
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_core_if.slave bus
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic ODD_BIT = (PARITY_ODD != 0);
    localparam logic HAS_PARITY = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e               state_q,      state_d;
    logic [CNT_W-1:0]     tick_cnt_q,   tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q,    bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic                 par_err_q,    par_err_d;
    logic [DATA_BITS-1:0] rx_data_q,    rx_data_d;
    logic                 rx_valid_q,   rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q,  frame_err_d;
    logic                 busy_q,       busy_d;
    logic                 sync1_q,      sync2_q;
    logic                 prev_rx_q;
    logic                 baud_q;

    logic rx_s;
    logic tick;
    logic tick_half;
    logic tick_last;
    logic last_bit;

    // A result of 1 means data bits plus received parity bit disagree with the selected sense.
    function automatic logic calc_parity_err(input logic [DATA_BITS-1:0] d, input logic p);
        return (^d) ^ p ^ ODD_BIT;
    endfunction

    assign rx_s      = sync2_q;
    assign tick      = bus.baud_clk & ~baud_q;
    assign tick_half = (tick_cnt_q == CNT_W'(OVERSAMPLE / 2 - 1));
    assign tick_last = (tick_cnt_q == CNT_W'(OVERSAMPLE - 1));
    assign last_bit  = (bit_cnt_q == BIT_W'(DATA_BITS - 1));

    // Next-state and output computation for the receive FSM.
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_err_d    = par_err_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        case (state_q)
            IDLE: begin
                // Edge detection runs every clk; a line stuck low after a break never restarts.
                if (!rx_s && prev_rx_q) begin
                    tick_cnt_d = '0;
                    state_d    = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_half) begin
                        if (!rx_s) begin
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                            state_d    = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_last) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (last_bit) begin
                            bit_cnt_d = '0;
                            state_d   = HAS_PARITY ? PARITY : STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (tick) begin
                    if (tick_last) begin
                        tick_cnt_d = '0;
                        par_err_d  = calc_parity_err(shift_q, rx_s);
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                // Outputs register on the sampling tick so rx_valid rises on the following cycle.
                if (tick) begin
                    if (tick_last) begin
                        tick_cnt_d   = '0;
                        rx_data_d    = shift_q;
                        frame_err_d  = ~rx_s;
                        parity_err_d = HAS_PARITY ? par_err_q : 1'b0;
                        rx_valid_d   = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, counters, synchronizer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_rx_q    <= 1'b1;
            baud_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_err_q    <= par_err_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
            sync1_q      <= bus.rx;
            sync2_q      <= sync1_q;
            prev_rx_q    <= sync2_q;
            baud_q       <= bus.baud_clk;
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = busy_q;
endmodule
